// File: rtl/uart_host_pkg.sv
// rtl/uart_host_pkg.sv - MiniUART register map, LSR bit positions and host FSM states
package uart_host_pkg;

    // Wishbone word address [4:2] of each MiniUART register
    localparam logic [2:0] REG_DATA = 3'b000;
    localparam logic [2:0] REG_LSR  = 3'b001;
    localparam logic [2:0] REG_DIVR = 3'b010;
    localparam logic [2:0] REG_DIVT = 3'b011;

    // Line status register bits
    localparam int LSR_TS = 5;  // transmitter idle
    localparam int LSR_RS = 0;  // byte received

    typedef enum logic [2:0] {
        ST_INIT_DIVR,
        ST_INIT_DIVT,
        ST_POLL,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_GUARD
    } state_t;

endpackage

// File: rtl/uart_host_byte_fifo.sv
// rtl/uart_host_byte_fifo.sv - byte-wide synchronous FIFO with occupancy count
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, push_data   write strobe and byte (ignored while full)
//   pop               read strobe (ignored while empty)
//   head              oldest byte; zero after reset
//   count             number of stored bytes, 0..DEPTH
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count != (AW+1)'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr] <= push_data;
                wptr      <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/uart_host.sv
// rtl/uart_host.sv - Wishbone initiator that programs and polls the MiniUART, bridging it to byte streams
//
// Ports:
//   CLK_I, RST_I                     clock, asynchronous active-high reset
//   ADD_O, DAT_O, DAT_I, STB_O,
//   WE_O, ACK_I                      Wishbone initiator towards the MiniUART
//   tx_byte, tx_valid, tx_ready      byte stream into the TX FIFO
//   rx_byte, rx_valid, rx_ready      byte stream out of the RX FIFO
//   init_done                        divisors have been programmed
//   rx_drop                          pulse: UART had a byte while the RX FIFO was full
module uart_host
    import uart_host_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [15:0] DIVR_INIT = 16'd1302,
    parameter logic [15:0] DIVT_INIT = 16'd2604,
    parameter int          GUARD     = 2
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    output logic [2:0]  ADD_O,
    output logic [31:0] DAT_O,
    input  logic [31:0] DAT_I,
    output logic        STB_O,
    output logic        WE_O,
    input  logic        ACK_I,
    input  logic [7:0]  tx_byte,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        init_done,
    output logic        rx_drop
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t        state_q, state_d;
    logic          stb_q, stb_d;
    logic          we_q, we_d;
    logic [2:0]    add_q, add_d;
    logic [31:0]   dat_q, dat_d;
    logic [7:0]    gcnt_q, gcnt_d;
    logic          init_q, init_d;
    logic          drop_q, drop_d;

    logic [CW-1:0] tx_count, rx_count;
    logic [7:0]    tx_head;
    logic          tx_empty, rx_full;
    logic          tx_pop, rx_push;
    logic          lsr_rs, lsr_ts;
    logic          unused_dat;

    assign tx_empty  = (tx_count == '0);
    assign rx_full   = (rx_count == CW'(DEPTH));
    assign tx_ready  = (tx_count != CW'(DEPTH));
    assign rx_valid  = (rx_count != '0);
    assign lsr_rs    = DAT_I[LSR_RS];
    assign lsr_ts    = DAT_I[LSR_TS];
    assign unused_dat = ^DAT_I;

    assign STB_O     = stb_q;
    assign WE_O      = we_q;
    assign ADD_O     = add_q;
    assign DAT_O     = dat_q;
    assign init_done = init_q;
    assign rx_drop   = drop_q;

    byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk       (CLK_I),
        .rst       (RST_I),
        .push      (tx_valid && tx_ready),
        .push_data (tx_byte),
        .pop       (tx_pop),
        .head      (tx_head),
        .count     (tx_count)
    );

    byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk       (CLK_I),
        .rst       (RST_I),
        .push      (rx_push),
        .push_data (DAT_I[7:0]),
        .pop       (rx_valid && rx_ready),
        .head      (rx_byte),
        .count     (rx_count)
    );

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= ST_INIT_DIVR;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            add_q   <= '0;
            dat_q   <= '0;
            gcnt_q  <= '0;
            init_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            add_q   <= add_d;
            dat_q   <= dat_d;
            gcnt_q  <= gcnt_d;
            init_q  <= init_d;
            drop_q  <= drop_d;
        end
    end

    // Each bus state spends one cycle with STB_O low (the idle cycle between
    // accesses), then raises the strobe and holds it until acknowledged.
    always_comb begin
        state_d = state_q;
        stb_d   = stb_q;
        we_d    = we_q;
        add_d   = add_q;
        dat_d   = dat_q;
        gcnt_d  = gcnt_q;
        init_d  = init_q;
        drop_d  = 1'b0;
        tx_pop  = 1'b0;
        rx_push = 1'b0;

        if (state_q == ST_GUARD) begin
            if (gcnt_q + 8'd1 >= 8'(GUARD)) begin
                state_d = ST_POLL;
            end else begin
                gcnt_d = gcnt_q + 8'd1;
            end
        end else if (!stb_q) begin
            stb_d = 1'b1;
            case (state_q)
                ST_INIT_DIVR: begin we_d = 1'b1; add_d = REG_DIVR; dat_d = {16'b0, DIVR_INIT}; end
                ST_INIT_DIVT: begin we_d = 1'b1; add_d = REG_DIVT; dat_d = {16'b0, DIVT_INIT}; end
                ST_POLL:      begin we_d = 1'b0; add_d = REG_LSR;  end
                ST_RD_DATA:   begin we_d = 1'b0; add_d = REG_DATA; end
                ST_WR_DATA:   begin we_d = 1'b1; add_d = REG_DATA; dat_d = {24'b0, tx_head}; end
                default:      begin stb_d = 1'b0; state_d = ST_INIT_DIVR; end
            endcase
        end else if (ACK_I) begin
            stb_d = 1'b0;
            we_d  = 1'b0;
            case (state_q)
                ST_INIT_DIVR: state_d = ST_INIT_DIVT;
                ST_INIT_DIVT: begin
                    state_d = ST_POLL;
                    init_d  = 1'b1;
                end
                ST_POLL: begin
                    // RX wins over TX; a byte that cannot be taken is flagged
                    // but does not block transmission.
                    drop_d = lsr_rs && rx_full;
                    if (lsr_rs && !rx_full) begin
                        state_d = ST_RD_DATA;
                    end else if (lsr_ts && !tx_empty) begin
                        state_d = ST_WR_DATA;
                    end else begin
                        state_d = ST_POLL;
                    end
                end
                ST_RD_DATA: begin
                    rx_push = 1'b1;
                    state_d = ST_POLL;
                end
                ST_WR_DATA: begin
                    // The UART needs a few cycles before ts reflects the new
                    // byte; GUARD keeps the next poll from seeing a stale ts=1.
                    tx_pop  = 1'b1;
                    gcnt_d  = '0;
                    state_d = ST_GUARD;
                end
                default: state_d = ST_INIT_DIVR;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_host.sv
// tb/tb_uart_host.sv - self-checking bench for uart_host against a behavioural MiniUART and stream model
module tb_uart_host;

    localparam int DEPTH = 4;
    localparam int GUARD = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  add;
    logic [31:0] dat_o;
    logic [31:0] dat_i = '0;
    logic        stb, we;
    logic        ack = 1'b0;
    logic [7:0]  tx_byte = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        init_done, rx_drop;

    always #5 clk = ~clk;

    uart_host #(
        .DEPTH(DEPTH), .DIVR_INIT(16'd1302), .DIVT_INIT(16'd2604), .GUARD(GUARD)
    ) dut (
        .CLK_I(clk), .RST_I(rst), .ADD_O(add), .DAT_O(dat_o), .DAT_I(dat_i),
        .STB_O(stb), .WE_O(we), .ACK_I(ack),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .init_done(init_done), .rx_drop(rx_drop)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Completed bus accesses, in order
    typedef struct {
        logic        we;
        logic [2:0]  addr;
        logic [31:0] data;
        int          cyc;
    } acc_t;
    acc_t blog[$];

    // MiniUART model and stream endpoints
    bit         m_rs = 0;
    bit         m_ts = 1;
    logic [7:0] m_rxd = '0;
    int         ts_busy = 0;
    bit         rs_auto = 0;
    bit         ack_rand = 0;
    bit         hold_wr = 0;
    int         rx_mode = 0;     // 0 never ready, 1 always, 2 random
    bit         pop_one = 0;
    logic [7:0] tx_src[$];
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    int         rx_occ = 0;
    bit         exp_drop = 0;
    int         drop_cnt = 0;
    int         cyc = 0;
    int         last_wr_cyc = 0;
    bit         gap_pending = 0;
    bit         stb_prev = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            ack = 1'b0; dat_i = '0; tx_valid = 1'b0; stb_prev = 0; exp_drop = 0;
        end else begin
            if (rx_drop || exp_drop) chk("rx_drop", rx_drop, exp_drop);
            if (rx_drop) drop_cnt++;
            exp_drop = 0;
            if (ts_busy > 0) begin
                ts_busy--;
                if (ts_busy == 0) m_ts = 1;
            end
            if (rs_auto && !m_rs && $urandom_range(0, 2) == 0) begin
                m_rxd = 8'($urandom);
                m_rs = 1;
                rx_exp.push_back(m_rxd);
            end
            if (stb && !stb_prev && gap_pending) begin
                int gap;
                gap = cyc - last_wr_cyc - 1;
                chk("guard_gap", (gap >= GUARD) ? GUARD : gap, GUARD);
                gap_pending = 0;
            end
            stb_prev = stb;
            ack = stb && !(hold_wr && we && add == 3'd0) && (!ack_rand || $urandom_range(0, 1) == 1);
            case (add)
                3'd1:    dat_i = {26'b0, m_ts, 4'b0, m_rs};
                3'd0:    dat_i = {24'b0, m_rxd};
                default: dat_i = '0;
            endcase
            if (ack) begin
                blog.push_back('{we, add, we ? dat_o : dat_i, cyc});
                if (add == 3'd0 && !we) begin
                    chk("rd_needs_rs", m_rs, 1);
                    m_rs = 0;
                    rx_occ++;
                end
                if (add == 3'd0 && we) begin
                    chk("wr_needs_ts", m_ts, 1);
                    if (tx_exp.size() == 0) chk("tx_unexpected", dat_o, 32'hFFFF_FFFF);
                    else begin
                        logic [7:0] e;
                        e = tx_exp.pop_front();
                        chk("tx_data", dat_o, {24'b0, e});
                    end
                    m_ts = 0;
                    ts_busy = $urandom_range(1, 6);
                    last_wr_cyc = cyc;
                    gap_pending = 1;
                end
                if (add == 3'd1 && !we && m_rs && rx_occ == DEPTH) exp_drop = 1;
            end
            rx_ready = (rx_mode == 1) || (rx_mode == 2 && $urandom_range(0, 1) == 1) || pop_one;
            pop_one = 0;
            if (rx_valid && rx_ready) begin
                if (rx_exp.size() == 0) chk("rx_unexpected", rx_byte, 32'hFFFF_FFFF);
                else begin
                    logic [7:0] e;
                    e = rx_exp.pop_front();
                    chk("rx_data", rx_byte, e);
                end
                rx_occ--;
            end
            tx_valid = (tx_src.size() != 0);
            tx_byte = tx_valid ? tx_src[0] : 8'h00;
            if (tx_valid && tx_ready) tx_exp.push_back(tx_src.pop_front());
        end
    end

    function automatic int find_data(input int from);
        for (int i = from; i < blog.size(); i++)
            if (blog[i].addr == 3'd0) return i;
        return -1;
    endfunction

    task automatic model_reset();
        tx_src.delete(); tx_exp.delete(); rx_exp.delete(); blog.delete();
        m_rs = 0; m_ts = 1; ts_busy = 0; rx_occ = 0; gap_pending = 0;
    endtask

    task automatic wait_log(input int n, input int budget, output bit ok);
        int b;
        b = budget;
        while (blog.size() < n && b > 0) begin
            @(posedge clk);
            b--;
        end
        #2;
        ok = (blog.size() >= n);
        if (!ok) chk("timeout_bus_log", blog.size(), n);
    endtask

    task automatic wait_drain(input int budget);
        int b;
        b = budget;
        while (!(tx_src.size() == 0 && tx_exp.size() == 0 && !m_rs && rx_exp.size() == 0) && b > 0) begin
            @(posedge clk);
            b--;
        end
        #1;
        chk("drain_done", b > 0, 1);
    endtask

    task automatic check_init();
        bit ok;
        wait_log(3, 80, ok);
        if (ok) begin
            chk("init_divr_we",   blog[0].we,   1);
            chk("init_divr_addr", blog[0].addr, 2);
            chk("init_divr_data", blog[0].data, 32'h516);
            chk("init_divt_we",   blog[1].we,   1);
            chk("init_divt_addr", blog[1].addr, 3);
            chk("init_divt_data", blog[1].data, 32'hA2C);
            chk("init_lsr_rd",    {blog[2].we, blog[2].addr}, {1'b0, 3'd1});
            chk("init_spacing",   blog[2].cyc - blog[1].cyc, 2);
            chk("init_done",      init_done, 1);
        end
    endtask

    typedef struct {
        bit         rs;
        logic [7:0] rxd;
        bit         ts;
        bit         push;
        logic [7:0] txd;
        int         kind;     // first DATA access: 0 none, 1 read, 2 write
        logic [7:0] data;
    } vec_t;
    vec_t tbl[7];

    initial begin
        int idx, k, d0;
        bit ok;

        tbl[0] = '{1, 8'h5A, 0, 0, 8'h00, 1, 8'h5A};
        tbl[1] = '{0, 8'h00, 1, 1, 8'h41, 2, 8'h41};
        tbl[2] = '{1, 8'hC3, 1, 1, 8'h42, 1, 8'hC3};
        tbl[3] = '{0, 8'h00, 1, 0, 8'h00, 0, 8'h00};
        tbl[4] = '{0, 8'h00, 0, 1, 8'h77, 0, 8'h00};
        tbl[5] = '{1, 8'h00, 1, 1, 8'hFF, 1, 8'h00};
        tbl[6] = '{0, 8'h00, 1, 1, 8'h80, 2, 8'h80};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stb", stb, 0);
        chk("rst_we", we, 0);
        chk("rst_add", add, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_byte", rx_byte, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_rx_drop", rx_drop, 0);
        @(posedge clk); #2 rst = 1'b0;
        check_init();

        rx_mode = 1;
        for (int i = 0; i < 7; i++) begin
            m_ts = 0; ts_busy = 0;
            if (tbl[i].push) tx_src.push_back(tbl[i].txd);
            repeat (6) @(posedge clk);
            #1;
            idx = blog.size();
            if (tbl[i].rs) begin
                m_rxd = tbl[i].rxd; m_rs = 1; rx_exp.push_back(tbl[i].rxd);
            end
            m_ts = tbl[i].ts;
            k = -1;
            for (int c = 0; c < 40 && k < 0; c++) begin
                @(posedge clk); #1;
                k = find_data(idx);
            end
            chk($sformatf("tbl%0d_kind", i), (k < 0) ? 0 : (blog[k].we ? 2 : 1), tbl[i].kind);
            if (k >= 0 && tbl[i].kind != 0)
                chk($sformatf("tbl%0d_data", i), blog[k].data, {24'b0, tbl[i].data});
            m_ts = 1;
            wait_drain(300);
        end

        // Two bytes back to back with the transmitter idle
        idx = blog.size();
        tx_src.push_back(8'h41); tx_src.push_back(8'h42);
        wait_drain(200);
        k = find_data(idx);
        chk("tx2_first", (k >= 0) ? blog[k].data : 32'hFFFF_FFFF, 32'h41);
        k = (k >= 0) ? find_data(k + 1) : -1;
        chk("tx2_second", (k >= 0) ? blog[k].data : 32'hFFFF_FFFF, 32'h42);

        // Fill the RX FIFO, then hold rs high
        rx_mode = 0;
        for (int i = 0; i < DEPTH; i++) begin
            int b;
            m_rxd = 8'h10 + 8'(i); m_rs = 1; rx_exp.push_back(m_rxd);
            b = 40;
            while (m_rs && b > 0) begin @(posedge clk); b--; end
            chk("rxfill_read", m_rs, 0);
        end
        repeat (4) @(posedge clk);
        #1;
        chk("rxfull_valid", rx_valid, 1);
        chk("rxfull_head", rx_byte, 8'h10);
        idx = blog.size(); d0 = drop_cnt;
        m_rxd = 8'hEE; m_rs = 1; rx_exp.push_back(8'hEE);
        repeat (30) @(posedge clk);
        #1;
        chk("rxfull_no_read", find_data(idx) >= 0, 0);
        chk("rxfull_drops", (drop_cnt - d0 >= 4) ? 1 : 0, 1);
        idx = blog.size();
        pop_one = 1;
        k = -1;
        for (int c = 0; c < 30 && k < 0; c++) begin
            @(posedge clk); #1;
            k = find_data(idx);
        end
        chk("rxpop_read", (k >= 0) ? {blog[k].we, blog[k].data[7:0]} : 9'h1FF, {1'b0, 8'hEE});
        rx_mode = 1;
        wait_drain(200);

        // Randomized traffic with wait states on the bus
        ack_rand = 1; rs_auto = 1; rx_mode = 2;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 7) == 0 && tx_src.size() < 3) tx_src.push_back(8'($urandom));
        end
        rs_auto = 0; rx_mode = 1;
        wait_drain(600);
        ack_rand = 0;

        // Reset while a DATA write strobe is held
        hold_wr = 1;
        for (int i = 0; i < DEPTH + 1; i++) tx_src.push_back(8'h90 + 8'(i));
        ok = 0;
        for (int c = 0; c < 80 && !ok; c++) begin
            @(posedge clk); #2;
            ok = stb && we && add == 3'd0 && !tx_ready;
        end
        chk("rst_mid_wr_seen", ok, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_stb", stb, 0);
        chk("rst_mid_tx_ready", tx_ready, 1);
        chk("rst_mid_init_done", init_done, 0);
        model_reset();
        hold_wr = 0;
        @(posedge clk); #2 rst = 1'b0;
        check_init();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
